// File: rtl/add_subt_pkg.sv
// rtl/add_subt_pkg.sv - shared state encoding and mode constants for add_subt_serial
package add_subt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_digit.sv
// rtl/add_digit.sv - combinational DIGIT-bit ripple adder slice with carry into its top bit
module add_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign sum   = full[DIGIT-1:0];
    assign cout  = full[DIGIT];
    // The top sum bit is a^b^carry_in, so the carry into it falls out directly.
    assign c_msb = a[DIGIT-1] ^ b[DIGIT-1] ^ full[DIGIT-1];

endmodule

// File: rtl/add_subt_serial.sv
// rtl/add_subt_serial.sv - digit-serial two's-complement adder/subtractor with valid/ready handshakes
module add_subt_serial
    import add_subt_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op0,
    input  logic [WIDTH-1:0] op1,
    input  logic             x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int OW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("add_subt_serial: WIDTH must be a positive multiple of DIGIT");
    end

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  res_reg;
    logic              carry;
    logic              ovf_reg;

    logic [OW-1:0]     base;
    logic              last;
    logic [DIGIT-1:0]  d_sum;
    logic              d_cout;
    logic              d_cmsb;

    assign base = OW'(cnt) * OW'(DIGIT);
    assign last = (cnt == CW'(N - 1));

    add_digit #(
        .DIGIT (DIGIT)
    ) u_add_digit (
        .a     (a_reg[base +: DIGIT]),
        .b     (b_reg[base +: DIGIT]),
        .cin   (carry),
        .sum   (d_sum),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is op0 + ~op1 + 1: invert on capture and seed the carry with the mode bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= op0;
                        b_reg   <= op1 ^ {WIDTH{x}};
                        carry   <= (x == MODE_SUB);
                        cnt     <= '0;
                        res_reg <= '0;
                        ovf_reg <= 1'b0;
                    end
                end
                RUN: begin
                    res_reg[base +: DIGIT] <= d_sum;
                    carry                  <= d_cout;
                    cnt                    <= last ? '0 : cnt + CW'(1);
                    if (last) begin
                        ovf_reg <= d_cmsb ^ d_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_reg;
    assign cout      = carry;
    assign overflow  = ovf_reg;

endmodule

// File: tb/tb_add_subt_serial.sv
// tb/tb_add_subt_serial.sv - self-checking bench: directed 16/4 cases plus randomized parameter sweep
module tb_add_subt_serial;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic clk;
    logic rst_s;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: {overflow, cout, result} from unsigned and signed integer arithmetic.
    function automatic logic [65:0] ref_op(input longint unsigned a, input longint unsigned b,
                                           input bit x, input int w);
        longint unsigned mask;
        longint unsigned res;
        longint          hi;
        longint          sa;
        longint          sb;
        longint          st;
        bit              c;
        bit              o;
        mask = (64'd1 << w) - 64'd1;
        hi   = longint'(64'd1 << (w - 1));
        sa   = longint'(a);
        sb   = longint'(b);
        if (a[w-1]) sa = sa - 2 * hi;
        if (b[w-1]) sb = sb - 2 * hi;
        if (x) begin
            res = (a - b) & mask;
            c   = (a >= b);
            st  = sa - sb;
        end else begin
            res = (a + b) & mask;
            c   = ((a + b) >> w) != 0;
            st  = sa + sb;
        end
        o = (st > hi - 1) || (st < -hi);
        return {o, c, res};
    endfunction

    // Main 16/4 instance with its own reset for the mid-operation reset case
    logic        m_rst;
    logic        m_iv;
    logic        m_ir;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic        m_x;
    logic        m_ov;
    logic        m_ordy;
    logic [15:0] m_res;
    logic        m_co;
    logic        m_of;

    add_subt_serial #(
        .WIDTH (16),
        .DIGIT (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (m_rst),
        .in_valid  (m_iv),
        .in_ready  (m_ir),
        .op0       (m_a),
        .op1       (m_b),
        .x         (m_x),
        .out_valid (m_ov),
        .out_ready (m_ordy),
        .result    (m_res),
        .cout      (m_co),
        .overflow  (m_of)
    );

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic x,
                          input logic [15:0] er, input logic ec, input logic eo, input int hold);
        logic [65:0] mdl;
        int          lat;
        logic [15:0] r0;
        logic        c0;
        logic        o0;
        mdl = ref_op(a, b, x, 16);
        chk("model_pin", {46'd0, mdl[65], mdl[64], mdl[15:0]}, {46'd0, eo, ec, er});
        @(negedge clk);
        chk("ready_before", m_ir, 1);
        m_a  = a;
        m_b  = b;
        m_x  = x;
        m_iv = 1'b1;
        @(negedge clk);
        m_iv = 1'b0;
        m_a  = 16'($urandom);
        m_b  = 16'($urandom);
        lat  = 0;
        while (!m_ov && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 4);
        chk("result", m_res, er);
        chk("cout", m_co, ec);
        chk("overflow", m_of, eo);
        chk("result_model", m_res, mdl[15:0]);
        chk("flags_model", {m_of, m_co}, mdl[65:64]);
        r0 = m_res;
        c0 = m_co;
        o0 = m_of;
        for (int i = 0; i < hold; i++) begin
            m_iv = 1'($urandom_range(0, 1));
            m_x  = 1'($urandom_range(0, 1));
            m_a  = 16'($urandom);
            m_b  = 16'($urandom);
            @(negedge clk);
            chk("hold_valid", m_ov, 1);
            chk("hold_ready", m_ir, 0);
            chk("hold_outputs", {m_of, m_co, m_res}, {o0, c0, r0});
        end
        m_iv   = 1'b0;
        m_ordy = 1'b1;
        @(negedge clk);
        m_ordy = 1'b0;
        chk("drained_valid", m_ov, 0);
        chk("drained_ready", m_ir, 1);
    endtask

    // Parameter sweep: randomized back-to-back traffic against the model
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W    = (g == 0) ? 8 : (g == 1) ? 16 : 32;
        localparam int D    = (g == 0) ? 1 : (g == 2) ? 4 : 16;
        localparam int NN   = W / D;
        localparam int NOPS = 20;

        logic         iv;
        logic         ir;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         xx;
        logic         ov;
        logic         ordy;
        logic [W-1:0] r;
        logic         co;
        logic         of;

        logic [65:0]  q[$];
        logic [65:0]  cur;
        bit           seen = 1'b0;
        int           since = 0;

        add_subt_serial #(
            .WIDTH (W),
            .DIGIT (D)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_s),
            .in_valid  (iv),
            .in_ready  (ir),
            .op0       (a),
            .op1       (b),
            .x         (xx),
            .out_valid (ov),
            .out_ready (ordy),
            .result    (r),
            .cout      (co),
            .overflow  (of)
        );

        function automatic logic [W-1:0] pick();
            case ($urandom_range(0, 5))
                0:       return '1;
                1:       return {1'b1, {(W-1){1'b0}}};
                2:       return '0;
                default: return W'($urandom);
            endcase
        endfunction

        always @(posedge clk) begin
            if (iv && ir) since = 0;
            else          since++;
            if (ov && ordy) seen = 1'b0;
        end

        always @(negedge clk) begin
            ordy = ($urandom_range(0, 3) != 0);
        end

        always @(negedge clk) begin
            if (rst_s && ov) begin
                if (!seen) begin
                    chk($sformatf("w%0d_d%0d latency", W, D), since, NN);
                    chk($sformatf("w%0d_d%0d queue", W, D), (q.size() > 0), 1);
                    cur  = (q.size() > 0) ? q.pop_front() : '0;
                    seen = 1'b1;
                end
                chk($sformatf("w%0d_d%0d result", W, D), r, cur[W-1:0]);
                chk($sformatf("w%0d_d%0d cout", W, D), co, cur[64]);
                chk($sformatf("w%0d_d%0d overflow", W, D), of, cur[65]);
                chk($sformatf("w%0d_d%0d busy_ready", W, D), ir, 0);
            end
        end

        initial begin : drv
            int t;
            iv = 1'b0;
            a  = '0;
            b  = '0;
            xx = 1'b0;
            t  = 0;
            while (!rst_s && t < 100) begin
                @(negedge clk);
                t++;
            end
            for (int k = 0; k < NOPS; k++) begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                    if (!ir) begin
                        iv = 1'($urandom_range(0, 1));
                        a  = pick();
                        b  = pick();
                        xx = 1'($urandom_range(0, 1));
                    end
                end while (!ir && t < 400);
                if (!ir) begin
                    chk($sformatf("w%0d_d%0d accept_timeout", W, D), ir, 1);
                    break;
                end
                a  = pick();
                b  = pick();
                xx = 1'($urandom_range(0, 1));
                iv = 1'b1;
                q.push_back(ref_op(a, b, xx, W));
            end
            @(negedge clk);
            iv = 1'b0;
            t  = 0;
            while ((q.size() != 0 || seen || ov) && t < 2000) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("w%0d_d%0d drain", W, D), q.size(), 0);
            done_cnt++;
        end
    end

    initial begin
        int t;
        rst_s  = 1'b0;
        m_rst  = 1'b0;
        m_iv   = 1'b0;
        m_a    = '0;
        m_b    = '0;
        m_x    = 1'b0;
        m_ordy = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {m_ov, m_of, m_co, m_res}, 19'd0);
        chk("reset_ready", m_ir, 1);
        rst_s = 1'b1;
        m_rst = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", {m_ov, m_of, m_co, m_res}, 19'd0);
        chk("post_reset_ready", m_ir, 1);

        run_op(16'd23, 16'd3, 1'b0, 16'd26, 1'b0, 1'b0, 0);
        run_op(16'd21, 16'd75, 1'b1, 16'hFFCA, 1'b0, 1'b0, 0);
        run_op(16'd16800, 16'd16900, 1'b0, 16'h83A4, 1'b0, 1'b1, 10);
        run_op(16'd6983, 16'd6650, 1'b1, 16'd333, 1'b1, 1'b0, 0);
        run_op(16'hFFFF, 16'd1, 1'b0, 16'd0, 1'b1, 1'b0, 0);
        run_op(16'h8000, 16'd1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 3);

        // Reset two digit cycles into an operation
        @(negedge clk);
        m_a  = 16'd1000;
        m_b  = 16'd2000;
        m_x  = 1'b0;
        m_iv = 1'b1;
        @(negedge clk);
        m_iv = 1'b0;
        repeat (2) @(negedge clk);
        m_rst = 1'b0;
        #1;
        chk("midrun_reset_outputs", {m_ov, m_of, m_co, m_res}, 19'd0);
        chk("midrun_reset_ready", m_ir, 1);
        @(negedge clk);
        m_rst = 1'b1;
        run_op(16'd325, 16'd97, 1'b0, 16'd422, 1'b0, 1'b0, 0);

        t = 0;
        while (done_cnt < 4 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("sweep_done", done_cnt, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
